pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Two-entry pipeline buffer placed between CPU pipeline stages (e.g. IF/ID, ID/EX); it is the reading/consuming end of an upstream stage's write.
- Accepts data from the upstream stage with a valid/ready handshake and presents it downstream with the same handshake.
- A skid slot lets out_up_ready be a registered signal, so there is no combinational path from in_dn_ready to out_up_ready.
- Supports pipeline flush for branch/exception squash.

Parameters:
- WIDTH, 32, data width in bits.

Ports:
- in_clk  input  1  clock; all state updates on the falling edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_flush  input  1  squash all buffered entries (synchronous, sampled at the falling edge).
- in_up_valid  input  1  upstream has data on in_up_data.
- in_up_data  input  WIDTH  upstream data.
- out_up_ready  output  1  buffer can accept a beat this cycle.
- out_dn_valid  output  1  out_dn_data holds a valid beat.
- out_dn_data  output  WIDTH  oldest buffered beat.
- in_dn_ready  input  1  downstream consumes the beat this cycle.
- out_count  output  2  number of buffered beats (0..2).

Behaviour:
- Reset (in_rst=1, asynchronous):
  - state is EMPTY; main slot = 0; skid slot = 0.
  - Outputs during and after reset: out_dn_valid=0, out_dn_data=0, out_up_ready=1, out_count=0.
  - All handshakes are ignored while in_rst=1.
  - Reset mid-operation discards every buffered beat immediately.
- Transfer definitions:
  - up transfer = in_up_valid & out_up_ready.
  - dn transfer = out_dn_valid & in_dn_ready.
  - Both are evaluated at the falling edge.
- Output decoding (from state only, never from inputs):
  - out_dn_valid = (state != EMPTY).
  - out_up_ready = (state != FULL).
  - out_dn_data = main slot.
  - out_count: EMPTY=0, ONE=1, FULL=2.
- State machine (encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2), updated at the falling edge:
  - EMPTY:
    - up transfer -> ONE, main <= in_up_data.
    - otherwise hold.
  - ONE:
    - up only -> FULL, skid <= in_up_data.
    - dn only -> EMPTY.
    - up and dn together -> stay ONE, main <= in_up_data.
    - neither -> hold.
  - FULL (out_up_ready=0, so no up transfer is possible):
    - dn transfer -> ONE, main <= skid.
    - otherwise hold.
  - Encoding 2'd3 is illegal; treat it as EMPTY on the next edge.
- Flush (in_flush=1 at the falling edge):
  - Highest priority after reset: next state = EMPTY regardless of handshakes.
  - A simultaneous up beat counts as accepted (out_up_ready was high) and is discarded.
  - A simultaneous dn beat counts as consumed.
  - Slot contents hold their old values; out_dn_valid=0 qualifies them.
- Latency:
  - A beat accepted at edge N appears on out_dn_data immediately after edge N (one cycle).
  - When the buffer is FULL, the skid beat reaches out_dn_data one edge after the main beat is consumed.
- Ordering: strict FIFO; no beat is lost or duplicated except by flush or reset.
- Data must not change in any slot on cycles without a transfer into that slot.
- Illegal but tolerated: in_up_valid dropping without a transfer; in_up_data changing while in_up_valid=1 and out_up_ready=0.

Decomposition:
- Shared package: state encoding constants (EMPTY/ONE/FULL) and the default WIDTH constant, so hazard/stall units can decode out_count.
- No sub-module is required. Main and skid slots are two enable-gated WIDTH-bit registers inline, both with asynchronous clear on in_rst.

Test Plan:
- Reset: assert in_rst mid-cycle while FULL holding 0x11111111/0x22222222 -> out_dn_valid=0, out_count=0, out_up_ready=1, out_dn_data=0 immediately, without waiting for a clock edge.
- Streaming: in_dn_ready=1, push 0xA0,0xA1,0xA2 on consecutive edges -> out_dn_data shows 0xA0,0xA1,0xA2 one edge after each push; out_count stays 1; out_up_ready stays 1.
- Backpressure: in_dn_ready=0, push 0xB0,0xB1 -> out_count=2 and out_up_ready=0. Then hold in_up_valid=1 with 0xB2 for 3 cycles -> 0xB2 is not accepted. Then set in_dn_ready=1 -> outputs 0xB0, then 0xB1, then 0xB2 in order with no loss.
- Simultaneous in ONE: main holds 0xC0, push 0xC1 with in_dn_ready=1 -> state stays ONE, out_dn_data=0xC1, skid unused.
- Flush: FULL with 0xD0/0xD1, assert in_flush together with in_dn_ready=1 -> next edge EMPTY, out_dn_valid=0. A following push of 0xD2 -> out_dn_data=0xD2 and no stale 0xD1 appears.
- Flush with an up beat: EMPTY, in_up_valid=1 with 0xE0 and in_flush=1 -> stays EMPTY. Next edge pushes 0xE1 -> 0xE1 is the only beat delivered.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the two-entry skid pipeline register, so hazard and
// stall logic can decode the buffer occupancy without reaching into the block.
package pipe_skid_reg_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // Occupancy seen by stall units; the unused encoding reads as empty.
    function automatic logic [1:0] count_of_state(input skid_state_t st);
        logic [1:0] cnt;
        cnt = 2'd0;
        case (st)
            ST_ONE:  cnt = 2'd1;
            ST_FULL: cnt = 2'd2;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline buffer between CPU stages. The skid slot keeps
// out_up_ready a pure function of registered state, so no in_dn_ready path.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_flush,
    input  logic             in_up_valid,
    input  logic [WIDTH-1:0] in_up_data,
    output logic             out_up_ready,
    output logic             out_dn_valid,
    output logic [WIDTH-1:0] out_dn_data,
    input  logic             in_dn_ready,
    output logic [1:0]       out_count
);

    // Handshake: a beat moves on a falling edge where valid and ready are both
    // high; ready never depends on the partner's valid, and valid never drops
    // on this side until the beat is taken (or the buffer is flushed/reset).

    skid_state_t      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             up_xfer;
    logic             dn_xfer;

    assign out_dn_valid = (state == ST_ONE) || (state == ST_FULL);
    assign out_up_ready = (state != ST_FULL);
    assign out_dn_data  = main_q;
    assign out_count    = count_of_state(state);

    assign up_xfer = in_up_valid & out_up_ready;
    assign dn_xfer = out_dn_valid & in_dn_ready;

    // Flush only redirects the state; slot contents are left alone because
    // out_dn_valid=0 already marks them as stale.
    always_ff @(negedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (in_flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        state  <= ST_ONE;
                        main_q <= in_up_data;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_q <= in_up_data;
                    end else if (up_xfer) begin
                        state  <= ST_FULL;
                        skid_q <= in_up_data;
                    end else if (dn_xfer) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dn_xfer) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: state updates on the falling edge, outputs
// are sampled 1 time unit after it, and expected values are written by hand.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         in_clk;
    logic         in_rst;
    logic         in_flush;
    logic         in_up_valid;
    logic [W-1:0] in_up_data;
    logic         out_up_ready;
    logic         out_dn_valid;
    logic [W-1:0] out_dn_data;
    logic         in_dn_ready;
    logic [1:0]   out_count;

    int errors = 0;
    int checks = 0;

    pipe_skid_reg #(.WIDTH(W)) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_flush    (in_flush),
        .in_up_valid (in_up_valid),
        .in_up_data  (in_up_data),
        .out_up_ready(out_up_ready),
        .out_dn_valid(out_dn_valid),
        .out_dn_data (out_dn_data),
        .in_dn_ready (in_dn_ready),
        .out_count   (out_count)
    );

    // Clock and reset
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(negedge in_clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        in_up_valid = 1'b1;
        in_up_data  = d;
    endtask

    task automatic idle();
        in_up_valid = 1'b0;
        in_up_data  = '0;
    endtask

    // Scenarios
    task automatic test_reset();
        in_rst = 1'b1; in_flush = 1'b0; in_dn_ready = 1'b0; idle();
        #1;
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL rst_init_valid: got %b want 0", out_dn_valid); end
        checks++; if (out_up_ready !== 1'b1) begin errors++; $display("FAIL rst_init_ready: got %b want 1", out_up_ready); end
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL rst_init_count: got %0d want 0", out_count); end
        checks++; if (out_dn_data !== 32'h0) begin errors++; $display("FAIL rst_init_data: got %h want 0", out_dn_data); end
        tick();
        in_rst = 1'b0;
        push(32'h11111111); tick();
        push(32'h22222222); tick();
        idle();
        checks++; if (out_count !== 2'd2) begin errors++; $display("FAIL rst_fill_count: got %0d want 2", out_count); end
        checks++; if (out_dn_data !== 32'h11111111) begin errors++; $display("FAIL rst_fill_data: got %h want 11111111", out_dn_data); end
        // Assert reset mid-cycle; effect must be immediate.
        #2;
        in_rst = 1'b1;
        #1;
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", out_dn_valid); end
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", out_count); end
        checks++; if (out_up_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", out_up_ready); end
        checks++; if (out_dn_data !== 32'h0) begin errors++; $display("FAIL rst_async_data: got %h want 0", out_dn_data); end
        // Handshakes during reset are ignored.
        push(32'h33333333); tick();
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL rst_hold_count: got %0d want 0", out_count); end
        checks++; if (out_dn_data !== 32'h0) begin errors++; $display("FAIL rst_hold_data: got %h want 0", out_dn_data); end
        idle();
        in_rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [W-1:0] vals [3];
        vals[0] = 32'hA0; vals[1] = 32'hA1; vals[2] = 32'hA2;
        in_dn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(vals[i]); tick();
            checks++; if (out_dn_data !== vals[i]) begin errors++; $display("FAIL stream_data%0d: got %h want %h", i, out_dn_data, vals[i]); end
            checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL stream_count%0d: got %0d want 1", i, out_count); end
            checks++; if (out_up_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, out_up_ready); end
        end
        idle(); tick();
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_dn_valid); end
    endtask

    task automatic test_backpressure();
        in_dn_ready = 1'b0;
        push(32'hB0); tick();
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL bp_count1: got %0d want 1", out_count); end
        push(32'hB1); tick();
        checks++; if (out_count !== 2'd2) begin errors++; $display("FAIL bp_count2: got %0d want 2", out_count); end
        checks++; if (out_up_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", out_up_ready); end
        push(32'hB2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_count !== 2'd2) begin errors++; $display("FAIL bp_hold_count%0d: got %0d want 2", i, out_count); end
            checks++; if (out_dn_data !== 32'hB0) begin errors++; $display("FAIL bp_hold_data%0d: got %h want b0", i, out_dn_data); end
        end
        in_dn_ready = 1'b1;
        tick();
        checks++; if (out_dn_data !== 32'hB1) begin errors++; $display("FAIL bp_out_b1: got %h want b1", out_dn_data); end
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL bp_count_b1: got %0d want 1", out_count); end
        tick();
        checks++; if (out_dn_data !== 32'hB2) begin errors++; $display("FAIL bp_out_b2: got %h want b2", out_dn_data); end
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL bp_count_b2: got %0d want 1", out_count); end
        idle(); tick();
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL bp_drain_count: got %0d want 0", out_count); end
    endtask

    task automatic test_simultaneous();
        in_dn_ready = 1'b0;
        push(32'hC0); tick();
        checks++; if (out_dn_data !== 32'hC0) begin errors++; $display("FAIL sim_c0: got %h want c0", out_dn_data); end
        in_dn_ready = 1'b1;
        push(32'hC1); tick();
        checks++; if (out_dn_data !== 32'hC1) begin errors++; $display("FAIL sim_c1: got %h want c1", out_dn_data); end
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL sim_count: got %0d want 1", out_count); end
        checks++; if (out_up_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b want 1", out_up_ready); end
        idle(); tick();
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL sim_drain_valid: got %b want 0", out_dn_valid); end
    endtask

    task automatic test_flush();
        in_dn_ready = 1'b0;
        push(32'hD0); tick();
        push(32'hD1); tick();
        checks++; if (out_count !== 2'd2) begin errors++; $display("FAIL fl_full_count: got %0d want 2", out_count); end
        idle();
        in_flush = 1'b1; in_dn_ready = 1'b1;
        tick();
        in_flush = 1'b0; in_dn_ready = 1'b0;
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", out_dn_valid); end
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL fl_count: got %0d want 0", out_count); end
        checks++; if (out_up_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b want 1", out_up_ready); end
        push(32'hD2); tick();
        checks++; if (out_dn_data !== 32'hD2) begin errors++; $display("FAIL fl_d2: got %h want d2", out_dn_data); end
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL fl_d2_count: got %0d want 1", out_count); end
        idle(); in_dn_ready = 1'b1; tick();
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stale: got valid %b data %h want valid 0", out_dn_valid, out_dn_data); end
    endtask

    task automatic test_flush_up();
        in_dn_ready = 1'b1;
        in_flush = 1'b1;
        push(32'hE0); tick();
        in_flush = 1'b0;
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL flu_valid: got %b want 0", out_dn_valid); end
        checks++; if (out_count !== 2'd0) begin errors++; $display("FAIL flu_count: got %0d want 0", out_count); end
        push(32'hE1); tick();
        checks++; if (out_dn_data !== 32'hE1) begin errors++; $display("FAIL flu_e1: got %h want e1", out_dn_data); end
        checks++; if (out_count !== 2'd1) begin errors++; $display("FAIL flu_e1_count: got %0d want 1", out_count); end
        idle(); tick();
        checks++; if (out_dn_valid !== 1'b0) begin errors++; $display("FAIL flu_only_e1: got valid %b data %h want valid 0", out_dn_valid, out_dn_data); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_flush_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
